step_controller: RTL and testbench
==================================

# step_controller

Run/pause/single-step sequencer for the program-counter and shifter datapath. It replaces the free-running derived 1 Hz clock with a single-cycle clock-enable pulse, `step_en`, that keeps the whole design on `in_clk`. The divide ratio is programmable at run time. An `out_clk` square wave is kept for the board LED. It sits between the board buttons/switches and the PC/shifter enables.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `TICK_HZ`, default 1: default step rate after reset.
- `CNT_W`, default 27: divider width; must hold `CLK_HZ/TICK_HZ`.

- `in_clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run_i`  in  1  level, already synchronised; 1 = free-run.
- `step_req`  in  1  one-cycle pulse, already debounced; requests a single step.
- `div_load`  in  1  one-cycle pulse; loads `div_val`.
- `div_val`  in  CNT_W  new divide ratio N (cycles per step).
- `step_en`  out  1  registered one-cycle enable to PC/shifter.
- `out_clk`  out  1  toggles on every `step_en`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `state_o`  out  2  current state encoding.
- `step_cnt`  out  16  count of `step_en` pulses, wraps 0xFFFF→0.

## Operation
- Reset values: state IDLE, `cnt`=0, `div_reg`=CLK_HZ/TICK_HZ, and all outputs 0.
- States, with encodings: IDLE=2'b00, RUN=2'b01, STEP=2'b10.
- IDLE:
  - `cnt` is held at 0 and no pulses are produced.
  - `run_i`=1 → RUN.
  - Else `step_req`=1 → STEP.
  - If both are high, RUN wins and `step_req` is dropped.
- STEP lasts exactly one cycle:
  - `step_en`=1 during it, then → IDLE unconditionally.
  - `step_req` arriving in STEP is dropped.
- RUN, evaluated at each edge:
  - If `div_load`: `cnt`←0 and no pulse.
  - Else if `cnt`==`div_reg`−1: `cnt`←0 and `step_en`←1.
  - Else `cnt`←`cnt`+1.
  - `run_i`=0 → IDLE with `cnt`←0; the partial period is discarded and no pulse is issued on that edge.
  - `step_req` is ignored in RUN.
- `div_load`, in any state: `div_reg`←`div_val`, except `div_val`=0 is stored as 1.
- `div_load` always clears `cnt` and takes priority over a wrap on the same edge.
- `out_clk` and `step_cnt` update on the edge after `step_en` is sampled high, i.e. each pulse produces one toggle and one increment.
- Asserting `rst_n` mid-period aborts the period and returns every register to its reset value immediately (asynchronous); no pulse is emitted.

## Timing
- Entering RUN at edge k:
  - First `step_en` is high in the cycle after edge k+N.
  - Subsequent pulses follow every N cycles.
- N=1: `step_en` is high every cycle from edge k+1 onward.
- `step_req` sampled at edge k in IDLE: `step_en` is high during cycle k+1 (state STEP). The earliest next accepted `step_req` is at edge k+2.
- `step_en` is always exactly one cycle wide and comes from a register (glitch-free).
- `busy` and `state_o` are registered and change on the same edge as the state.
- Deassertion of `rst_n` is expected to be synchronised externally; the block makes no guarantee for a release near an edge.

## Structure
- Shared package `step_ctrl_pkg` holds:
  - the state enum/localparams (IDLE/RUN/STEP);
  - the default divide constant `DEF_DIV = CLK_HZ/TICK_HZ`;
  - the `CNT_W` sizing rule.
- One sub-module `tick_counter` with:
  - inputs `in_clk`, `rst_n`, `en`, `clr`, `limit[CNT_W-1:0]`;
  - output `wrap`, asserted combinationally when `en && cnt==limit−1`;
  - `clr` overriding `en`.
- The top level holds the FSM, `div_reg`, the output registers and `step_cnt`.

## Test plan
- Reset/default:
  - Setup: CLK_HZ=10, TICK_HZ=1; hold `rst_n`=0, release, then `run_i`=1 at edge 0.
  - Required: `step_en` pulses after edges 10, 20, 30; `out_clk` reads 1, 0, 1 after each pulse; `step_cnt`=3.
- Single step:
  - Stimulus: in IDLE, `step_req` at edge 5.
  - Required: `step_en`=1 only in cycle 6; `state_o`=2'b10 then 2'b00; a second `step_req` at edge 6 is dropped, so `step_cnt`=1.
- Reload mid-run:
  - Stimulus: in RUN with N=10 and `cnt`=7, `div_load` with `div_val`=3.
  - Required: no pulse on that edge; next pulses 3 and 6 cycles later.
  - Also: `div_val`=0 gives a pulse every cycle.
- Pause/resume:
  - Stimulus: N=10; drop `run_i` with `cnt`=8; raise it again 4 cycles later.
  - Required: no pulse on the drop edge; first pulse a full 10 cycles after re-entry.
- Collisions:
  - `run_i` and `step_req` both high in IDLE → RUN with no STEP pulse.
  - `div_load` coinciding with a wrap → no pulse, `cnt`=0.
- Async reset mid-operation:
  - Stimulus: assert `rst_n`=0 between edges while `cnt`=5 and `step_cnt`=0x0042.
  - Required: all outputs read 0 and `div_reg`=10 immediately.
  - Also, `step_cnt` wrap: preload 0xFFFF via stepping, then one pulse → 0x0000.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the step controller.
package step_ctrl_pkg;

    // Encodings are visible on state_o, so they are fixed explicitly.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StStep = 2'b10
    } state_e;

    localparam int unsigned DEF_CLK_HZ  = 100_000_000;
    localparam int unsigned DEF_TICK_HZ = 1;
    localparam int unsigned DEF_DIV     = DEF_CLK_HZ / DEF_TICK_HZ;

    // Divider must be able to hold the ratio itself (cnt runs 0..N-1, div_reg holds N).
    function automatic int unsigned cnt_w_for(input int unsigned div);
        return $clog2(div + 1);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_w_for(DEF_DIV);

endpackage

// File: rtl/step_controller_tick_counter.sv
// Period counter: counts 0..limit-1 while enabled, flags the last count.
module tick_counter #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             in_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign wrap = en && (cnt_q == limit - CNT_W'(1));

    // Clear beats enable; wrap restarts the period at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Period count register.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/step_controller.sv
// Run/pause/single-step sequencer producing a one-cycle step_en clock enable.
module step_controller
    import step_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
    parameter int unsigned TICK_HZ = DEF_TICK_HZ,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             in_clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             step_req,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             step_en,
    output logic             out_clk,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic [15:0]      step_cnt
);

    localparam logic [CNT_W-1:0] ResetDiv = CNT_W'(CLK_HZ / TICK_HZ);

    state_e           state_q;
    logic             step_en_q;
    logic             busy_q;
    logic             out_clk_q;
    logic [15:0]      step_cnt_q;
    logic [CNT_W-1:0] div_q;
    logic             run_en;
    logic             cnt_clr;
    logic             wrap;

    // Counter only advances while staying in RUN; anything else parks it at zero.
    assign run_en  = (state_q == StRun) && run_i;
    assign cnt_clr = div_load || !run_en;

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .in_clk (in_clk),
        .rst_n  (rst_n),
        .en     (run_en),
        .clr    (cnt_clr),
        .limit  (div_q),
        .wrap   (wrap)
    );

    // FSM with registered step_en and busy.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            step_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            step_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (run_i) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end else if (step_req) begin
                        state_q   <= StStep;
                        step_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StRun: begin
                    if (!run_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (wrap && !div_load) begin
                        step_en_q <= 1'b1;
                    end
                end
                StStep: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Divide ratio, LED toggle and pulse count; a zero ratio is treated as one.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= ResetDiv;
            out_clk_q  <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            if (div_load) begin
                div_q <= (div_val == '0) ? CNT_W'(1) : div_val;
            end
            if (step_en_q) begin
                out_clk_q  <= ~out_clk_q;
                step_cnt_q <= step_cnt_q + 16'd1;
            end
        end
    end

    assign step_en  = step_en_q;
    assign out_clk  = out_clk_q;
    assign busy     = busy_q;
    assign state_o  = state_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with a 10:1 divider.
module tb_step_controller;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             run_i;
    logic             step_req;
    logic             div_load;
    logic [CNT_W-1:0] div_val;
    logic             step_en;
    logic             out_clk;
    logic             busy;
    logic [1:0]       state_o;
    logic [15:0]      step_cnt;

    int n_cmp;
    int n_err;

    step_controller #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .CNT_W   (CNT_W)
    ) dut (
        .in_clk   (clk),
        .rst_n    (rst_n),
        .run_i    (run_i),
        .step_req (step_req),
        .div_load (div_load),
        .div_val  (div_val),
        .step_en  (step_en),
        .out_clk  (out_clk),
        .busy     (busy),
        .state_o  (state_o),
        .step_cnt (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".step_en"}, 32'(step_en), 32'd0);
        check_eq({tag, ".out_clk"}, 32'(out_clk), 32'd0);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".state"}, 32'(state_o), 32'd0);
        check_eq({tag, ".step_cnt"}, 32'(step_cnt), 32'd0);
        check_eq({tag, ".div"}, 32'(dut.div_q), 32'd10);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        run_i    = 1'b0;
        step_req = 1'b0;
        div_load = 1'b0;
        div_val  = '0;

        // Reset values.
        #12;
        check_all_zero("rst");
        rst_n = 1'b1;

        // Free run at N=10: pulses after edges 10, 20, 30.
        run_i = 1'b1;
        tick();
        check_eq("run_entry.state", 32'(state_o), 32'd1);
        check_eq("run_entry.busy", 32'(busy), 32'd1);
        for (int j = 1; j <= 31; j++) begin
            tick();
            check_eq($sformatf("run10.step_en[%0d]", j), 32'(step_en), 32'(j % 10 == 0));
            check_eq($sformatf("run10.out_clk[%0d]", j), 32'(out_clk), 32'(((j - 1) / 10) % 2));
            check_eq($sformatf("run10.step_cnt[%0d]", j), 32'(step_cnt), 32'((j - 1) / 10));
        end
        run_i = 1'b0;
        tick();
        check_eq("stop.state", 32'(state_o), 32'd0);
        check_eq("stop.busy", 32'(busy), 32'd0);

        // Single step; a request during STEP is dropped.
        step_req = 1'b1;
        tick();
        check_eq("step.step_en", 32'(step_en), 32'd1);
        check_eq("step.state", 32'(state_o), 32'd2);
        check_eq("step.busy", 32'(busy), 32'd1);
        tick();
        check_eq("step_drop.step_en", 32'(step_en), 32'd0);
        check_eq("step_drop.state", 32'(state_o), 32'd0);
        step_req = 1'b0;
        tick();
        check_eq("step_after.step_en", 32'(step_en), 32'd0);
        check_eq("step_after.step_cnt", 32'(step_cnt), 32'd4);
        check_eq("step_after.out_clk", 32'(out_clk), 32'd0);

        // Reload to N=3 with cnt=7.
        run_i = 1'b1;
        tick();
        repeat (7) tick();
        div_load = 1'b1;
        div_val  = 8'd3;
        tick();
        check_eq("reload.step_en", 32'(step_en), 32'd0);
        div_load = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            check_eq($sformatf("run3.step_en[%0d]", j), 32'(step_en), 32'(j == 3 || j == 6));
        end

        // Zero ratio behaves as N=1.
        div_load = 1'b1;
        div_val  = 8'd0;
        tick();
        check_eq("load0.step_en", 32'(step_en), 32'd0);
        check_eq("load0.div", 32'(dut.div_q), 32'd1);
        div_load = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            check_eq($sformatf("run1.step_en[%0d]", j), 32'(step_en), 32'd1);
        end

        // Load on a wrap edge: no pulse, period restarts from zero.
        div_load = 1'b1;
        div_val  = 8'd10;
        tick();
        check_eq("load_wrap.step_en", 32'(step_en), 32'd0);
        div_load = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            check_eq($sformatf("post_load.step_en[%0d]", j), 32'(step_en), 32'(j == 10));
        end

        // Pause at cnt=8, resume four cycles later: full period.
        repeat (8) tick();
        run_i = 1'b0;
        tick();
        check_eq("pause.step_en", 32'(step_en), 32'd0);
        check_eq("pause.state", 32'(state_o), 32'd0);
        repeat (3) tick();
        run_i = 1'b1;
        tick();
        for (int j = 1; j <= 10; j++) begin
            tick();
            check_eq($sformatf("resume.step_en[%0d]", j), 32'(step_en), 32'(j == 10));
        end
        run_i = 1'b0;
        tick();

        // run_i and step_req together: RUN wins.
        run_i    = 1'b1;
        step_req = 1'b1;
        tick();
        check_eq("both.state", 32'(state_o), 32'd1);
        check_eq("both.step_en", 32'(step_en), 32'd0);
        step_req = 1'b0;
        tick();
        check_eq("both2.step_en", 32'(step_en), 32'd0);
        run_i = 1'b0;
        tick();

        // Async reset mid-period with step_cnt=0x42, cnt=5, div=7.
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        div_load = 1'b1;
        div_val  = 8'd7;
        tick();
        div_load = 1'b0;
        for (int j = 0; j < 66; j++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            tick();
        end
        run_i = 1'b1;
        tick();
        repeat (5) tick();
        check_eq("pre_rst.step_cnt", 32'(step_cnt), 32'h42);
        check_eq("pre_rst.div", 32'(dut.div_q), 32'd7);
        check_eq("pre_rst.busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        run_i = 1'b0;
        #1;
        check_all_zero("async_rst");
        rst_n = 1'b1;

        // step_cnt wrap: 65535 pulses at N=1, then one step.
        tick();
        div_load = 1'b1;
        div_val  = 8'd0;
        tick();
        div_load = 1'b0;
        run_i    = 1'b1;
        tick();
        repeat (65535) tick();
        run_i = 1'b0;
        tick();
        check_eq("wrap_pre.step_cnt", 32'(step_cnt), 32'hFFFF);
        check_eq("wrap_pre.state", 32'(state_o), 32'd0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        check_eq("wrap.step_cnt", 32'(step_cnt), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
